// File: rtl/ahbl_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_cmd_master
// Description : Single-outstanding AHB-Lite initiator. It turns one
//               valid/ready command into one NONSEQ transfer and returns a
//               single-cycle completion pulse with read data or an error.
//               Misaligned or oversized commands complete with an error and
//               never reach the bus.
// Ports       : HCLK, HRESETn          - clock, async active-low reset
//               cmd_valid/cmd_ready    - command handshake
//               cmd_write/addr/size/wdata - command payload (wdata lane-placed)
//               rsp_valid/rsp_rdata/rsp_err - completion pulse and result
//               HADDR/HTRANS/HSIZE/HWRITE/HWDATA - AHB-Lite initiator outputs
//               HREADY/HRDATA          - AHB-Lite responder returns
// Options     : AHBL_CMD_MASTER_TIMEOUT_EN - abort a data phase after
//               TIMEOUT_CYCLES consecutive wait cycles (otherwise wait forever)
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_ADDR  = 2'd1;
    localparam logic [1:0]  c_ST_DATA  = 2'd2;
    localparam logic [1:0]  c_ST_RESP  = 2'd3;
    localparam logic [1:0]  c_TRANS_IDLE   = 2'b00;
    localparam logic [1:0]  c_TRANS_NONSEQ = 2'b10;
    localparam logic [31:0] c_ERR_RDATA    = 32'hBADD_BEEF;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("ahbl_cmd_master: TIMEOUT_CYCLES must be in 2..65535");
    end

    logic [1:0]  state_q,     state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] haddr_q,     haddr_d;
    logic [1:0]  htrans_q,    htrans_d;
    logic [2:0]  hsize_q,     hsize_d;
    logic        hwrite_q,    hwrite_d;
    logic [31:0] hwdata_q,    hwdata_d;
    logic [31:0] wdata_q,     wdata_d;
    logic        w_cmd_illegal;

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        w_cmd_illegal = (cmd_size > 3'd2)
                      | ((cmd_size == 3'd1) & cmd_addr[0])
                      | ((cmd_size == 3'd2) & (cmd_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;     // completion flags live for the RESP cycle only
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            c_ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (w_cmd_illegal) begin
                        state_d     = c_ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = c_ERR_RDATA;
                    end else begin
                        state_d  = c_ST_ADDR;
                        htrans_d = c_TRANS_NONSEQ;
                        haddr_d  = cmd_addr;
                        hsize_d  = {1'b0, cmd_size[1:0]};
                        hwrite_d = cmd_write;
                        wdata_d  = cmd_wdata;
                    end
                end
            end
            c_ST_ADDR: begin
                // Address outputs simply hold while the responder stalls.
                if (HREADY) begin
                    state_d  = c_ST_DATA;
                    htrans_d = c_TRANS_IDLE;
                    hwdata_d = wdata_q;
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
                    wait_cnt_d = 16'd0;
`endif
                end
            end
            c_ST_DATA: begin
                if (HREADY) begin
                    state_d     = c_ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = hwrite_q ? 32'd0 : HRDATA;
                end
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
                else if (wait_cnt_q == c_WAIT_LAST) begin
                    // This stall is the TIMEOUT_CYCLES-th in a row: give up.
                    state_d     = c_ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = c_ERR_RDATA;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`else
                // Without the timeout option the data phase waits forever.
`endif
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
        // Registered ready tracks the state being entered, so it is high
        // exactly while in IDLE and rises on the first edge after reset.
        cmd_ready_d = (state_d == c_ST_IDLE);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= c_ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            haddr_q     <= 32'd0;
            htrans_q    <= c_TRANS_IDLE;
            hsize_q     <= 3'd0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= 32'd0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HSIZE     = hsize_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ahbl_cmd_master
// Description : Self-checking bench for ahbl_cmd_master. A per-command
//               reference model derives latency, bus activity and the
//               completion result from the command and the wait-state
//               schedule; directed cases plus randomized commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_cmd_master;

    localparam int unsigned T_OUT = 4;
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [31:0] BAD = 32'hBADD_BEEF;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_size = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = '0;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rdata = '0;

    always #5 HCLK = ~HCLK;

    ahbl_cmd_master #(.TIMEOUT_CYCLES(T_OUT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One command. aw/dw are the responder's address/data-phase wait states.
    // Cycle c=1 is the cycle right after the handshake edge.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input int aw, input int dw,
                          input logic [31:0] rdata);
        bit          illegal;
        bit          tmo;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        illegal = (size > 3'd2) || (size == 3'd1 && addr[0]) ||
                  (size == 3'd2 && addr[1:0] != 2'b00);
        tmo = !illegal && TO_EN && (dw >= int'(T_OUT));
        if (illegal) begin
            lat = 1; exp_err = 1'b1; exp_rd = BAD;
        end else if (tmo) begin
            lat = aw + int'(T_OUT) + 2; exp_err = 1'b1; exp_rd = BAD;
        end else begin
            lat = aw + dw + 3; exp_err = 1'b0; exp_rd = wr ? 32'd0 : rdata;
        end

        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_size = size;  cmd_wdata = wdata; HREADY = 1'b1;
        tick();
        // Scramble the command inputs: the DUT must have latched them.
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_write = ~wr;  cmd_size = 3'($urandom);

        for (int c = 1; c <= lat; c++) begin
            chk("rsp_valid", 32'(rsp_valid), (c == lat) ? 32'd1 : 32'd0);
            if (c < lat) begin
                chk("rsp_err_idle", 32'(rsp_err), 32'd0);
                chk("rsp_rdata_hold", rsp_rdata, last_rdata);
                chk("ready_busy", 32'(cmd_ready), 32'd0);
            end else begin
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
                chk("rsp_rdata", rsp_rdata, exp_rd);
            end
            if (!illegal && c <= aw + 1) begin
                chk("htrans_nonseq", 32'(HTRANS), 32'd2);
                chk("haddr", HADDR, addr);
                chk("hsize", 32'(HSIZE), 32'(size));
                chk("hwrite", 32'(HWRITE), 32'(wr));
            end else begin
                chk("htrans_idle", 32'(HTRANS), 32'd0);
            end
            if (!illegal && wr && c >= aw + 2 && c < lat)
                chk("hwdata", HWDATA, wdata);
            HREADY = (c == aw + 1) || (c == aw + dw + 2);
            HRDATA = (c == aw + dw + 2) ? rdata : $urandom;
            tick();
        end

        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("rsp_err_drop", 32'(rsp_err), 32'd0);
        chk("rsp_rdata_after", rsp_rdata, exp_rd);
        chk("htrans_after", 32'(HTRANS), 32'd0);
        last_rdata = exp_rd;
        HREADY = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  s;

        // Reset state
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        tick();
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // Zero-wait write, then read with address and data waits
        do_cmd(1'b1, 32'h4000_0004, 3'd2, 32'hA5A5_1234, 0, 0, 32'h0);
        do_cmd(1'b0, 32'h4100_0000, 3'd2, 32'h0, 2, 3, 32'hDEAD_0001);

        // Illegal commands: misaligned word, misaligned half, oversized
        do_cmd(1'b0, 32'h4000_0002, 3'd2, 32'h0, 0, 0, 32'h1234_5678);
        do_cmd(1'b1, 32'h4000_0001, 3'd1, 32'h1111_2222, 0, 0, 32'h0);
        do_cmd(1'b0, 32'h4000_0000, 3'd3, 32'h0, 0, 0, 32'h0);
        // Legal half and byte at odd-ish addresses
        do_cmd(1'b0, 32'h4000_0006, 3'd1, 32'h0, 1, 0, 32'h0BAD_F00D);
        do_cmd(1'b0, 32'h4000_0003, 3'd0, 32'h0, 0, 1, 32'h0000_00C3);

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                            : 3'($urandom_range(0, 2));
            do_cmd(1'($urandom), a, s, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 6), $urandom);
        end

        // Long data-phase stall: aborts with timeout enabled, else waits it out
        do_cmd(1'b0, 32'h4200_0010, 3'd2, 32'h0, 0, 1000, 32'hCAFE_0002);

        // Load a non-zero read result, then reset in the middle of a write DATA
        do_cmd(1'b0, 32'h4300_0000, 3'd2, 32'h0, 0, 0, 32'h7777_8888);
        chk("ready_pre_rst", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0008;
        cmd_size = 3'd2;  cmd_wdata = 32'h5A5A_C3C3; HREADY = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        chk("mid_data_hwdata", HWDATA, 32'h5A5A_C3C3);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_htrans", 32'(HTRANS), 32'd0);
        chk("arst_hwdata", HWDATA, 32'd0);
        chk("arst_haddr", HADDR, 32'd0);
        chk("arst_hwrite", 32'(HWRITE), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_rdata", rsp_rdata, 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        HREADY = 1'b1;
        #1;
        chk("arst_ready_hold", 32'(cmd_ready), 32'd0);
        tick();
        chk("arst_ready_rise", 32'(cmd_ready), 32'd1);
        last_rdata = 32'd0;

        // Normal operation resumes after the reset
        do_cmd(1'b0, 32'h4000_0020, 3'd2, 32'h0, 1, 1, 32'h1357_9BDF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahbl_cmd_master.md
AHBL_CMD_MASTER -- requirements
Module: ahbl_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: consecutive data-phase wait cycles before abort; legal range 2..65535.
REQ-002 SHALL have HCLK  input  1  bus clock; every flop clocked on its rising edge.
REQ-003 SHALL have HRESETn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have cmd_valid  input  1  command request.
REQ-005 SHALL have cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 SHALL have cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have cmd_addr  input  32  byte address.
REQ-008 SHALL have cmd_size  input  3  AHB HSIZE encoding.
REQ-009 SHALL have cmd_wdata  input  32  write data, already lane-placed by the caller.
REQ-010 SHALL have rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have rsp_rdata  output  32  read data; 0 for writes.
REQ-012 SHALL have rsp_err  output  1  completion with error.
REQ-013 SHALL have HADDR  output  32, HTRANS  output  2, HSIZE  output  3, HWRITE  output  1, HWDATA  output  32: AHB-Lite initiator outputs.
REQ-014 SHALL have HREADY  input  1 and HRDATA  input  32: AHB-Lite responder returns.

Function
REQ-015 SHALL use FSM states IDLE, ADDR, DATA, RESP; every output SHALL be driven from a register.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a handshake is cmd_valid & cmd_ready at a rising edge.
REQ-017 On a legal handshake, the FSM SHALL go to ADDR and latch addr, size, write and wdata.
REQ-018 In ADDR: HTRANS = 2'b10 (NONSEQ); HADDR, HSIZE and HWRITE driven from latched values; HSIZE limited to 0..2.
REQ-019 In ADDR, HADDR, HTRANS, HSIZE and HWRITE SHALL stay stable while HREADY = 0; the FSM SHALL go to DATA at the first edge with HREADY = 1.
REQ-020 In every state other than ADDR, HTRANS SHALL be 2'b00 (IDLE).
REQ-021 In DATA, HWDATA SHALL hold the latched wdata until the phase completes.
REQ-022 DATA SHALL complete at the first edge with HREADY = 1; for reads, rsp_rdata captures HRDATA at that edge.
REQ-023 After DATA completes, the FSM SHALL go to RESP with rsp_valid = 1 and rsp_err = 0, for exactly one cycle, then return to IDLE.
REQ-024 Minimum transfer latency is 3 cycles: handshake edge to rsp_valid, zero wait states. A new command is accepted the cycle after RESP.
REQ-025 A misaligned or illegal command SHALL produce no bus transfer and go directly to RESP with rsp_err = 1 and rsp_rdata = 32'hBADDBEEF. Illegal means any of:
- cmd_size > 2;
- size 1 with addr[0] = 1;
- size 2 with addr[1:0] != 0.
REQ-026 rsp_rdata SHALL hold its value until the next completion; rsp_err SHALL clear to 0 when rsp_valid deasserts.

Reset
REQ-027 Asserting HRESETn low SHALL, asynchronously and at any state (including mid-ADDR or mid-DATA), force:
- FSM to IDLE, with the timeout counter at 0;
- HTRANS = 0, HADDR = 0, HSIZE = 0, HWRITE = 0, HWDATA = 0;
- cmd_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
REQ-028 cmd_ready SHALL rise at the first rising HCLK edge after HRESETn deasserts.

Configuration
REQ-029 Macro AHBL_CMD_MASTER_TIMEOUT_EN defined: a 16-bit counter SHALL count consecutive DATA cycles with HREADY = 0.
- On reaching TIMEOUT_CYCLES, the FSM SHALL abandon the phase and go to RESP with rsp_err = 1 and rsp_rdata = 32'hBADDBEEF.
- The counter SHALL clear on entry to DATA.
REQ-030 Macro undefined: no counter is present; DATA waits indefinitely and rsp_err is asserted only per REQ-025.

Verification
REQ-031 Write 0x4000_0004, size 2, wdata 0xA5A5_1234, HREADY always 1 -> NONSEQ for 1 cycle with HADDR 0x4000_0004, HWRITE 1; HWDATA 0xA5A5_1234 next cycle; rsp_valid 3 cycles after handshake, rsp_err 0.
REQ-032 Read 0x4100_0000 with HREADY low for 2 cycles in ADDR and 3 in DATA, HRDATA 0xDEAD_0001 -> address outputs stable throughout ADDR; rsp_rdata 0xDEAD_0001; latency 8 cycles.
REQ-033 Read with size 2 at addr 0x4000_0002 -> HTRANS stays 0; rsp_valid next cycle with rsp_err 1 and rsp_rdata 0xBADD_BEEF.
REQ-034 With the macro defined and TIMEOUT_CYCLES = 4, HREADY held low in DATA -> rsp_err 1 after 4 wait cycles; FSM in IDLE. With the macro undefined -> no rsp_valid for 1000 cycles.
REQ-035 HRESETn pulsed low during DATA of a write -> HTRANS, HWDATA and rsp_valid go to 0 immediately; cmd_ready is 1 one edge after release.
